run_controller: RTL

Synthesisable run/clock-enable controller for the 8-bit machine. It replaces the bare free-running clock enable with a parametrised controller that gates a `cpu_en` qualifier to the CPU. Run modes are free-run, single-step and run-N-cycles. It counts executed cycles, stops on CPU halt, external abort or a watchdog timeout, and reports why it stopped. It sits between the board/bench control inputs and the machine's clock-enable input.

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/run_controller_sat_counter.sv | 37 +++
 rtl/run_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/clock-enable controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'd0,
    MODE_STEP  = 2'd1,
    MODE_COUNT = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_HALT    = 3'd1,
    ST_TIMEOUT = 3'd2,
    ST_LIMIT   = 3'd3,
    ST_ABORT   = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

endpackage

// File: rtl/run_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes the value it
// will take on the next edge so the caller can make decisions on it.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: increment unless already at all-ones; clear wins.
  always_comb begin
    count_next = count_q;
    if (inc && (count_q != '1)) begin
      count_next = count_q + WIDTH'(1);
    end
    count_d = clr ? '0 : count_next;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/run_controller.sv
// Run / clock-enable controller: gates cpu_en for free-run, single-step and
// run-N-cycles modes, counts enabled cycles and reports why a run stopped.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int CYCLE_W = 16,
  parameter int TIMEOUT = 10000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CYCLE_W-1:0] run_count,
  input  logic               step,
  input  logic               abort,
  input  logic               halted,
  output logic               cpu_en,
  output logic               busy,
  output logic               done,
  output logic [2:0]         status,
  output logic [CYCLE_W-1:0] cycles
);

  localparam logic [CYCLE_W-1:0] TIMEOUT_V = CYCLE_W'(TIMEOUT);
  localparam bit                 WDOG_EN   = (TIMEOUT != 0);

  state_e             state_q, state_d;
  logic               count_mode_q, count_mode_d;
  logic [CYCLE_W-1:0] run_count_q, run_count_d;
  logic               cpu_en_q, cpu_en_d;
  logic               done_q, done_d;
  status_e            status_q, status_d;
  status_e            cause;
  logic               cyc_clr;
  logic [CYCLE_W-1:0] cycles_q;
  logic [CYCLE_W-1:0] cycles_nx;

  // Enabled-cycle counter; cpu_en_q is already low in IDLE, so it only
  // advances while a run is granting cycles (including the final one).
  sat_counter #(.WIDTH(CYCLE_W)) u_cycles (
    .clk        (clk),
    .rst        (reset),
    .clr        (cyc_clr),
    .inc        (cpu_en_q),
    .count      (cycles_q),
    .count_next (cycles_nx)
  );

  // Next-state, enable and termination decisions.
  always_comb begin
    state_d      = state_q;
    count_mode_d = count_mode_q;
    run_count_d  = run_count_q;
    cpu_en_d     = 1'b0;
    done_d       = 1'b0;
    status_d     = status_q;
    cyc_clr      = 1'b0;
    cause        = ST_NONE;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cyc_clr      = 1'b1;
          status_d     = ST_NONE;
          count_mode_d = (mode == MODE_COUNT);
          run_count_d  = run_count;
          if (abort) begin
            done_d   = 1'b1;
            status_d = ST_ABORT;
          end else if (halted) begin
            done_d   = 1'b1;
            status_d = ST_HALT;
          end else if ((mode == MODE_COUNT) && (run_count == '0)) begin
            done_d   = 1'b1;
            status_d = ST_LIMIT;
          end else if (mode == MODE_STEP) begin
            state_d = S_STEP;
          end else begin
            // FREE, COUNT and the reserved encoding all free-run.
            state_d  = S_RUN;
            cpu_en_d = 1'b1;
          end
        end
      end

      S_RUN, S_STEP: begin
        if (abort) begin
          cause = ST_ABORT;
        end else if (halted) begin
          cause = ST_HALT;
        end else if (WDOG_EN && (cycles_nx == TIMEOUT_V)) begin
          cause = ST_TIMEOUT;
        end else if (count_mode_q && (cycles_nx == run_count_q)) begin
          cause = ST_LIMIT;
        end

        if (cause != ST_NONE) begin
          state_d  = S_IDLE;
          done_d   = 1'b1;
          status_d = cause;
        end else begin
          cpu_en_d = (state_q == S_RUN) ? 1'b1 : step;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_mode_q <= 1'b0;
      run_count_q  <= '0;
      cpu_en_q     <= 1'b0;
      done_q       <= 1'b0;
      status_q     <= ST_NONE;
    end else begin
      state_q      <= state_d;
      count_mode_q <= count_mode_d;
      run_count_q  <= run_count_d;
      cpu_en_q     <= cpu_en_d;
      done_q       <= done_d;
      status_q     <= status_d;
    end
  end

  assign cpu_en = cpu_en_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign status = status_q;
  assign cycles = cycles_q;

endmodule
